mem_port_arbiter: RTL and testbench

Arbitrates one single-port unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage MIPS pipeline. Each side sees a request/ready handshake plus a combinational stall. The backing memory gets one registered command stream with a fixed, parameterised access latency. The block sits between `PCOutF`/`InstructionF` on the fetch side, `ALUResultM`/`ReadData2M`/`MemTypeM` on the data side, and the shared memory array; its stall outputs feed the existing hazard/stall logic.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_latency_counter.sv | 39 +++
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY, DONE)
//   owner_e     : which pipeline side currently owns the memory
//   MT_*        : access-size encodings carried on DType / MemType
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [1:0] MT_WORD = 2'b11;
  localparam logic [1:0] MT_HALF = 2'b01;
  localparam logic [1:0] MT_BYTE = 2'b00;

endpackage

// File: rtl/mem_arb_latency_counter.sv
// Latency counter for one memory transaction.
//   clk, rst : clock and asynchronous active-high reset
//   load     : clear the count to zero (start of a transaction)
//   inc      : advance the count by one
//   tc       : terminal count, high while the count equals LATENCY-1
module mem_arb_latency_counter #(
  parameter int LATENCY = 2,
  localparam int CW = $clog2(LATENCY + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CW'(LATENCY - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch stage
// (instruction reads) and the memory stage (loads/stores).
//   Clk, Reset                        : clock, async active-high reset
//   IReq/IAddr -> IRdata/IReady       : fetch read handshake
//   DReq/DWe/DAddr/DWdata/DType
//               -> DRdata/DReady      : data load/store handshake
//   StallF, StallM                    : combinational stalls to hazard unit
//   MemEn/MemWe/MemAddr/MemWdata/MemType : registered memory command
//   MemRdata                          : memory read data (final BUSY cycle)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter bit TIE_D_FIRST = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IReady,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  input  logic [1:0]  DType,
  output logic [31:0] DRdata,
  output logic        DReady,
  output logic        StallF,
  output logic        StallM,
  output logic        MemEn,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic [1:0]  MemType,
  input  logic [31:0] MemRdata
);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        last_d_q, last_d_d;
  logic        i_drop_q, i_drop_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_type_q, mem_type_d;

  logic grant_i;
  logic grant_d;
  logic cnt_load;
  logic cnt_inc;
  logic cnt_tc;

  mem_arb_latency_counter #(.LATENCY(LATENCY)) u_cnt (
    .clk  (Clk),
    .rst  (Reset),
    .load (cnt_load),
    .inc  (cnt_inc),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d_d    = last_d_q;
    i_drop_d    = i_drop_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_type_d  = mem_type_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the side not served last wins.
        if (IReq && DReq) begin
          grant_d = ~last_d_q;
          grant_i = last_d_q;
        end else begin
          grant_i = IReq;
          grant_d = DReq;
        end
      end
      ST_BUSY: begin
        cnt_inc = 1'b1;
        // A fetch whose request drops is a flushed fetch: it still
        // completes on the memory side but must not report ready.
        if (owner_q == OWN_I && !IReq) begin
          i_drop_d = 1'b1;
        end
        if (cnt_tc) begin
          if (owner_q == OWN_I) begin
            i_rdata_d = MemRdata;
            i_ready_d = IReq & ~i_drop_q;
          end else begin
            if (!mem_we_q) begin
              d_rdata_d = MemRdata;
            end
            d_ready_d = 1'b1;
          end
          last_d_d    = (owner_q == OWN_D);
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_type_d  = '0;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // The owner's request is still high here but already consumed,
        // so only the other side may be granted straight away.
        if (owner_q == OWN_I) begin
          grant_d = DReq;
        end else begin
          grant_i = IReq;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (grant_d) begin
      owner_d     = OWN_D;
      mem_en_d    = 1'b1;
      mem_we_d    = DWe;
      mem_addr_d  = DAddr;
      mem_wdata_d = DWdata;
      mem_type_d  = DType;
      cnt_load    = 1'b1;
      state_d     = ST_BUSY;
    end else if (grant_i) begin
      owner_d     = OWN_I;
      i_drop_d    = 1'b0;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = IAddr;
      mem_wdata_d = '0;
      mem_type_d  = MT_WORD;
      cnt_load    = 1'b1;
      state_d     = ST_BUSY;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_I;
      last_d_q    <= !TIE_D_FIRST;
      i_drop_q    <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_type_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_d_q    <= last_d_d;
      i_drop_q    <= i_drop_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_type_q  <= mem_type_d;
    end
  end

  assign IRdata   = i_rdata_q;
  assign IReady   = i_ready_q;
  assign DRdata   = d_rdata_q;
  assign DReady   = d_ready_q;
  assign MemEn    = mem_en_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWdata = mem_wdata_q;
  assign MemType  = mem_type_q;
  assign StallF   = IReq & ~i_ready_q;
  assign StallM   = DReq & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a LATENCY=2 instance driven through fetch,
// tie, store, same-side repeat, flush and reset-abort scenarios, plus a
// LATENCY=1 instance for the short-latency timing.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        IReq, DReq, DWe;
  logic [31:0] IAddr, DAddr, DWdata;
  logic [1:0]  DType;
  logic [31:0] IRdata, DRdata;
  logic        IReady, DReady, StallF, StallM;
  logic        MemEn, MemWe;
  logic [31:0] MemAddr, MemWdata, MemRdata;
  logic [1:0]  MemType;

  logic        IReq1, DReq1, DWe1;
  logic [31:0] IAddr1, DAddr1, DWdata1;
  logic [1:0]  DType1;
  logic [31:0] IRdata1, DRdata1;
  logic        IReady1, DReady1, StallF1, StallM1;
  logic        MemEn1, MemWe1;
  logic [31:0] MemAddr1, MemWdata1, MemRdata1;
  logic [1:0]  MemType1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c;
  exp_t expI[$];
  exp_t expD[$];
  exp_t exp1[$];
  logic [31:0] lastDLoad;

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Backing-memory model: fixed contents, data presented while enabled.
  function automatic logic [31:0] memData(input logic [31:0] addr);
    if (addr == 32'h10) return 32'h2402000A;
    return 32'hA5000000 | addr;
  endfunction

  assign MemRdata  = MemEn  ? memData(MemAddr)  : 32'h0;
  assign MemRdata1 = MemEn1 ? memData(MemAddr1) : 32'h0;

  mem_port_arbiter #(.LATENCY(2), .TIE_D_FIRST(1'b1)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IReady(IReady),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata), .DType(DType),
    .DRdata(DRdata), .DReady(DReady),
    .StallF(StallF), .StallM(StallM),
    .MemEn(MemEn), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemType(MemType), .MemRdata(MemRdata)
  );

  mem_port_arbiter #(.LATENCY(1), .TIE_D_FIRST(1'b1)) u_dut1 (
    .Clk(Clk), .Reset(Reset),
    .IReq(IReq1), .IAddr(IAddr1), .IRdata(IRdata1), .IReady(IReady1),
    .DReq(DReq1), .DWe(DWe1), .DAddr(DAddr1), .DWdata(DWdata1), .DType(DType1),
    .DRdata(DRdata1), .DReady(DReady1),
    .StallF(StallF1), .StallM(StallM1),
    .MemEn(MemEn1), .MemWe(MemWe1), .MemAddr(MemAddr1), .MemWdata(MemWdata1),
    .MemType(MemType1), .MemRdata(MemRdata1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%08h expected 0x%08h",
               name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwe,
                               input logic [31:0] daddr, input logic [31:0] dwdata,
                               input logic [1:0] dtype);
    IReq   = ireq;
    IAddr  = iaddr;
    DReq   = dreq;
    DWe    = dwe;
    DAddr  = daddr;
    DWdata = dwdata;
    DType  = dtype;
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic stepTo(input int n);
    while (cyc < n) nextCycle();
  endtask

  task automatic sampleAt(input int n);
    stepTo(n);
    @(negedge Clk);
  endtask

  // Scoreboard monitors: every Ready pulse pops the oldest expectation.
  always @(negedge Clk) begin : monI
    exp_t e;
    if (IReady === 1'b1) begin
      if (expI.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL IReady unexpected (cycle %0d): got 1 expected 0", cyc);
      end else begin
        e = expI.pop_front();
        checkOutput("IReady cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("IRdata", IRdata, e.data);
      end
    end
  end

  always @(negedge Clk) begin : monD
    exp_t e;
    if (DReady === 1'b1) begin
      if (expD.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL DReady unexpected (cycle %0d): got 1 expected 0", cyc);
      end else begin
        e = expD.pop_front();
        checkOutput("DReady cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("DRdata", DRdata, e.data);
      end
    end
  end

  always @(negedge Clk) begin : mon1
    exp_t e;
    if (DReady1 === 1'b1 || IReady1 === 1'b1) begin
      if (exp1.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL L1 Ready unexpected (cycle %0d): got 1 expected 0", cyc);
      end else begin
        e = exp1.pop_front();
        checkOutput("L1 Ready cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("L1 DRdata", DRdata1, e.data);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, MT_WORD);
    IReq1 = 1'b0; IAddr1 = '0; DReq1 = 1'b0; DWe1 = 1'b0;
    DAddr1 = '0; DWdata1 = '0; DType1 = MT_WORD;
    lastDLoad = 32'h0;

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutput("reset IReady", 32'(IReady), 32'h0);
    checkOutput("reset DReady", 32'(DReady), 32'h0);
    checkOutput("reset IRdata", IRdata, 32'h0);
    checkOutput("reset DRdata", DRdata, 32'h0);
    checkOutput("reset MemEn", 32'(MemEn), 32'h0);
    checkOutput("reset MemWe", 32'(MemWe), 32'h0);
    checkOutput("reset MemAddr", MemAddr, 32'h0);
    checkOutput("reset MemWdata", MemWdata, 32'h0);
    checkOutput("reset MemType", 32'(MemType), 32'h0);
    nextCycle();
    Reset = 1'b0;
    nextCycle();

    // Fetch only; the address change during BUSY must be ignored.
    $display("[TB] fetch only");
    c = cyc;
    IReq = 1'b1; IAddr = 32'h10;
    expI.push_back('{c + 3, 32'h2402000A});
    @(negedge Clk);
    checkOutput("fetch StallF c0", 32'(StallF), 32'h1);
    checkOutput("fetch MemEn c0", 32'(MemEn), 32'h0);
    stepTo(c + 1);
    IAddr = 32'h99;
    @(negedge Clk);
    checkOutput("fetch StallF c1", 32'(StallF), 32'h1);
    checkOutput("fetch MemEn c1", 32'(MemEn), 32'h1);
    checkOutput("fetch MemAddr c1", MemAddr, 32'h10);
    checkOutput("fetch MemType c1", 32'(MemType), 32'(MT_WORD));
    checkOutput("fetch MemWe c1", 32'(MemWe), 32'h0);
    sampleAt(c + 2);
    checkOutput("fetch StallF c2", 32'(StallF), 32'h1);
    checkOutput("fetch MemAddr c2", MemAddr, 32'h10);
    sampleAt(c + 3);
    checkOutput("fetch StallF c3", 32'(StallF), 32'h0);
    checkOutput("fetch MemEn c3", 32'(MemEn), 32'h0);
    stepTo(c + 4);
    IReq = 1'b0; IAddr = 32'h0;
    stepTo(c + 6);

    // Tie straight after reset: data side first, fetch granted from DONE.
    $display("[TB] tie after reset");
    Reset = 1'b1;
    nextCycle();
    Reset = 1'b0;
    nextCycle();
    c = cyc;
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h80, 32'h0, MT_WORD);
    expD.push_back('{c + 3, memData(32'h80)});
    expI.push_back('{c + 6, memData(32'h20)});
    lastDLoad = memData(32'h80);
    @(negedge Clk);
    checkOutput("tie StallF c0", 32'(StallF), 32'h1);
    checkOutput("tie StallM c0", 32'(StallM), 32'h1);
    stepTo(c + 4);
    DReq = 1'b0;
    @(negedge Clk);
    checkOutput("tie MemAddr fetch", MemAddr, 32'h20);
    checkOutput("tie MemEn fetch", 32'(MemEn), 32'h1);
    stepTo(c + 7);
    IReq = 1'b0;
    stepTo(c + 9);

    // Data-only byte load, then a tie: fetch must win this time.
    $display("[TB] tie after data served");
    c = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0, MT_BYTE);
    expD.push_back('{c + 3, memData(32'h84)});
    sampleAt(c + 1);
    checkOutput("byte MemType", 32'(MemType), 32'(MT_BYTE));
    stepTo(c + 4);
    DReq = 1'b0;
    stepTo(c + 5);
    c = cyc;
    applyStimulus(1'b1, 32'h24, 1'b1, 1'b0, 32'h88, 32'h0, MT_WORD);
    expI.push_back('{c + 3, memData(32'h24)});
    expD.push_back('{c + 6, memData(32'h88)});
    lastDLoad = memData(32'h88);
    stepTo(c + 4);
    IReq = 1'b0;
    stepTo(c + 7);
    DReq = 1'b0;
    stepTo(c + 9);

    // Half-word store: write strobe for exactly LATENCY cycles, DRdata kept.
    $display("[TB] store");
    c = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, MT_HALF);
    expD.push_back('{c + 3, lastDLoad});
    @(negedge Clk);
    checkOutput("store MemWe c0", 32'(MemWe), 32'h0);
    checkOutput("store StallM c0", 32'(StallM), 32'h1);
    sampleAt(c + 1);
    checkOutput("store MemWe c1", 32'(MemWe), 32'h1);
    checkOutput("store MemType c1", 32'(MemType), 32'(MT_HALF));
    checkOutput("store MemAddr c1", MemAddr, 32'h40);
    checkOutput("store MemWdata c1", MemWdata, 32'hDEADBEEF);
    sampleAt(c + 2);
    checkOutput("store MemWe c2", 32'(MemWe), 32'h1);
    checkOutput("store MemType c2", 32'(MemType), 32'(MT_HALF));
    sampleAt(c + 3);
    checkOutput("store MemWe c3", 32'(MemWe), 32'h0);
    checkOutput("store MemType c3", 32'(MemType), 32'h0);
    checkOutput("store StallM c3", 32'(StallM), 32'h0);
    stepTo(c + 4);
    DReq = 1'b0; DWe = 1'b0;
    stepTo(c + 6);

    // Same-side repeat with DReq held: one IDLE cycle between grants.
    $display("[TB] same-side repeat");
    c = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h90, 32'h0, MT_WORD);
    expD.push_back('{c + 3, memData(32'h90)});
    expD.push_back('{c + 7, memData(32'h94)});
    stepTo(c + 4);
    DAddr = 32'h94;
    @(negedge Clk);
    checkOutput("repeat MemEn idle gap", 32'(MemEn), 32'h0);
    stepTo(c + 8);
    DReq = 1'b0;
    lastDLoad = memData(32'h94);
    stepTo(c + 10);

    // Flushed fetch: request drops in the second BUSY cycle.
    $display("[TB] flushed fetch");
    c = cyc;
    IReq = 1'b1; IAddr = 32'h30;
    sampleAt(c + 1);
    checkOutput("flush MemEn c1", 32'(MemEn), 32'h1);
    stepTo(c + 2);
    IReq = 1'b0; IAddr = 32'h0;
    @(negedge Clk);
    checkOutput("flush MemEn c2", 32'(MemEn), 32'h1);
    checkOutput("flush StallF c2", 32'(StallF), 32'h0);
    sampleAt(c + 3);
    checkOutput("flush IReady c3", 32'(IReady), 32'h0);
    checkOutput("flush MemEn c3", 32'(MemEn), 32'h0);
    sampleAt(c + 4);
    checkOutput("flush IRdata", IRdata, memData(32'h30));
    stepTo(c + 5);
    c = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, MT_WORD);
    expD.push_back('{c + 3, memData(32'h44)});
    stepTo(c + 4);
    DReq = 1'b0;
    stepTo(c + 6);

    // Reset mid-BUSY aborts the store; a later load completes normally.
    $display("[TB] reset mid-busy");
    c = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h50, 32'h12345678, MT_WORD);
    sampleAt(c + 1);
    checkOutput("abort MemWe before", 32'(MemWe), 32'h1);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("abort MemEn now", 32'(MemEn), 32'h0);
    checkOutput("abort MemWe now", 32'(MemWe), 32'h0);
    checkOutput("abort MemAddr now", MemAddr, 32'h0);
    DReq = 1'b0; DWe = 1'b0;
    stepTo(c + 3);
    Reset = 1'b0;
    @(negedge Clk);
    checkOutput("abort DReady c3", 32'(DReady), 32'h0);
    stepTo(c + 5);
    c = cyc;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0, MT_WORD);
    expD.push_back('{c + 3, memData(32'h60)});
    stepTo(c + 4);
    DReq = 1'b0;
    stepTo(c + 6);

    // LATENCY=1 instance: Ready two cycles after the request.
    $display("[TB] latency one");
    c = cyc;
    DReq1 = 1'b1; DAddr1 = 32'h70;
    exp1.push_back('{c + 2, memData(32'h70)});
    sampleAt(c + 1);
    checkOutput("L1 MemEn c1", 32'(MemEn1), 32'h1);
    sampleAt(c + 2);
    checkOutput("L1 MemEn c2", 32'(MemEn1), 32'h0);
    stepTo(c + 3);
    DReq1 = 1'b0;
    stepTo(c + 6);

    checkOutput("expI drained", 32'(expI.size()), 32'h0);
    checkOutput("expD drained", 32'(expD.size()), 32'h0);
    checkOutput("exp1 drained", 32'(exp1.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
